// File: rtl/seq_mult_pkg.sv
// Shared types for the sequential shift-add multiplier: FSM state encoding and counter sizing.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must hold values 0..width.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/cond_negate.sv
// Conditional two's-complement negator; purely combinational, no flow control.
module cond_negate #(
    parameter int W = 8
) (
    input  logic [W-1:0] din,
    input  logic         neg,
    output logic [W-1:0] dout
);

    always_comb begin
        dout = neg ? (~din + W'(1)) : din;
    end

endmodule

// File: rtl/seq_array_multiplier.sv
// Sequential WIDTH x WIDTH shift-add multiplier, signed or unsigned; result WIDTH cycles after accept.
// Accepts only in IDLE; the product is held in DONE until out_ready.
module seq_array_multiplier
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p
);

    localparam int CW = cnt_width(WIDTH);

    state_t               state;
    state_t               state_nxt;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        cnt;
    logic                 neg;

    logic                 neg_a;
    logic                 neg_b;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   acc_nxt;
    logic [2*WIDTH-1:0]   p_nxt;
    logic                 last;

    assign neg_a = signed_mode & a[WIDTH-1];
    assign neg_b = signed_mode & b[WIDTH-1];

    cond_negate #(.W(WIDTH)) u_neg_a (
        .din  (a),
        .neg  (neg_a),
        .dout (mag_a)
    );

    cond_negate #(.W(WIDTH)) u_neg_b (
        .din  (b),
        .neg  (neg_b),
        .dout (mag_b)
    );

    // The extra adder bit keeps the carry, which lands in the accumulator MSB after the shift.
    always_comb begin
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : {WIDTH{1'b0}})};
        acc_nxt = {sum, acc[WIDTH-1:1]};
        last    = (cnt == CW'(WIDTH - 1));
    end

    cond_negate #(.W(2*WIDTH)) u_neg_p (
        .din  (acc_nxt),
        .neg  (neg),
        .dout (p_nxt)
    );

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = rst_n;
                if (in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            p      <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand  <= mag_a;
                        mplier <= mag_b;
                        neg    <= neg_a ^ neg_b;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    acc    <= acc_nxt;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        p <= p_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_array_multiplier.sv
// Randomised and directed bench for seq_array_multiplier with a queue-based scoreboard.
module tb_seq_array_multiplier;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           signed_mode = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [2*W-1:0] p;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rdy_mode = 0;

    logic [2*W-1:0] exp_q[$];
    int             acc_t_q[$];

    logic [2*W-1:0] prev_p = '0;
    bit             prev_valid = 1'b0;
    bit             prev_hs = 1'b0;

    seq_array_multiplier #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .p           (p)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Reference: plain integer multiplication of the interpreted operands.
    function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        longint px;
        longint py;
        longint r;
        px = longint'(x);
        py = longint'(y);
        if (s && x[W-1]) px = px - (longint'(1) << W);
        if (s && y[W-1]) py = py - (longint'(1) << W);
        r = px * py;
        return r[2*W-1:0];
    endfunction

    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ism);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        a = ia;
        b = ib;
        signed_mode = ism;
        in_valid = 1'b1;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(model(ia, ib, ism));
                acc_t_q.push_back(cyc + 1);
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        signed_mode = 1'($urandom);
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
    endtask

    // Drive a one-cycle in_valid pulse while the block is busy; it must be refused.
    task automatic poke_junk();
        @(posedge clk);
        #1;
        a = W'($urandom);
        b = W'($urandom);
        signed_mode = 1'($urandom);
        in_valid = 1'b1;
        @(negedge clk);
        check("busy_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out_valid();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        if (!seen) check("out_valid_timeout", 32'd0, 32'd1);
    endtask

    // Monitor: pops the scoreboard on each handoff and checks latency, hold and ready behaviour.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_hs = 1'b0;
        end else begin
            if (prev_hs) begin
                check("ready_after_handoff", 32'(in_ready), 32'd1);
                check("valid_drop_after_handoff", 32'(out_valid), 32'd0);
            end
            if (out_valid) begin
                check("in_ready_in_done", 32'(in_ready), 32'd0);
                if (!prev_valid) begin
                    if (acc_t_q.size() == 0) begin
                        check("unexpected_result", 32'd1, 32'd0);
                    end else begin
                        check("latency", 32'(cyc - acc_t_q.pop_front()), 32'(W));
                    end
                end else begin
                    check("hold_p", 32'(p), 32'(prev_p));
                end
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("scoreboard_empty", 32'd1, 32'd0);
                    end else begin
                        check("product", 32'(p), 32'(exp_q.pop_front()));
                    end
                end
            end
            prev_valid = out_valid && !out_ready;
            prev_hs = out_valid && out_ready;
            prev_p = p;
        end
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_p", 32'(p), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("release_in_ready", 32'(in_ready), 32'd1);

        // Directed products
        issue(8'd13, 8'd11, 1'b0);
        issue(8'd255, 8'd255, 1'b0);
        issue(8'hFD, 8'd5, 1'b1);
        issue(8'h80, 8'h80, 1'b1);
        issue(8'h80, 8'h7F, 1'b1);
        issue(8'h00, 8'h80, 1'b1);
        issue(8'h7F, 8'h80, 1'b0);

        // Backpressure with refused in_valid pulses during RUN and DONE
        wait_out_valid();
        rdy_mode = 2;
        issue(8'd200, 8'd3, 1'b0);
        poke_junk();
        poke_junk();
        wait_out_valid();
        for (int i = 0; i < 20; i++) begin
            if (i % 5 == 0) poke_junk();
            else @(negedge clk);
        end
        rdy_mode = 0;

        // Reset during RUN discards the operation
        wait_out_valid();
        repeat (3) @(posedge clk);
        issue(8'd100, 8'd3, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        acc_t_q.delete();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("midrst_out_valid", 32'(out_valid), 32'd0);
            check("midrst_p", 32'(p), 32'd0);
            check("midrst_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_release_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 12; i++) begin
            check("post_rst_no_result", 32'(out_valid), 32'd0);
            check("post_rst_p", 32'(p), 32'd0);
            @(negedge clk);
        end
        issue(8'd7, 8'd6, 1'b0);

        // Randomised operands with random output backpressure
        rdy_mode = 1;
        for (int i = 0; i < 60; i++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom));
        end
        issue(8'h00, 8'h00, 1'b1);
        issue(8'h01, 8'hFF, 1'b1);
        issue(8'hFF, 8'hFF, 1'b1);

        begin
            int n;
            n = 0;
            while (exp_q.size() != 0 && n < 2000) begin
                @(negedge clk);
                n++;
            end
            if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
        end
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
